// File: rtl/ecc_addsub_seq_ctrl.sv
// ecc_addsub_seq_ctrl
//   Sequences one external RADIX-bit adder over REG_SIZE-bit operands, least
//   significant word first. Operand words are read from a memory with one
//   cycle of read latency. The carry is chained between words through a
//   register. Each adder sum is written straight to the result memory. The
//   final carry-out is reported on carry_o. For subtraction the B word is
//   inverted and the carry chain is seeded with 1, which gives a + ~b + 1.
//
// Optional feature (macro ECC_ADDSUB_ZEROIZE_EN):
//   Adds the zeroize_i input. While it is high, the adder drives and
//   wr_data_o are forced to 0. On the next clock edge all state clears
//   exactly as on reset. zeroize_i has priority over start_i.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   start_i, sub_i           start request and mode (1 = a - b), sampled in IDLE
//   rd_en_o, rd_addr_o       operand read strobe and word address
//   a_i, b_i                 operand words, valid one cycle after the read
//   add_a_o, add_b_o,
//   add_cin_o                drives into the shared adder
//   add_s_i, add_cout_i      sum and carry back from the adder
//   wr_en_o, wr_addr_o,
//   wr_data_o                result word write port
//   busy_o                   high whenever the FSM is not in IDLE
//   done_o                   one-cycle completion pulse
//   carry_o                  final carry (add overflow / subtract no-borrow)
module ecc_addsub_seq_ctrl #(
  parameter int REG_SIZE = 384,
  parameter int RADIX    = 32,
  localparam int WORDS   = REG_SIZE / RADIX,
  localparam int AW      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ECC_ADDSUB_ZEROIZE_EN
  input  logic             zeroize_i,
`endif
  input  logic             start_i,
  input  logic             sub_i,
  output logic             rd_en_o,
  output logic [AW-1:0]    rd_addr_o,
  input  logic [RADIX-1:0] a_i,
  input  logic [RADIX-1:0] b_i,
  output logic [RADIX-1:0] add_a_o,
  output logic [RADIX-1:0] add_b_o,
  output logic             add_cin_o,
  input  logic [RADIX-1:0] add_s_i,
  input  logic             add_cout_i,
  output logic             wr_en_o,
  output logic [AW-1:0]    wr_addr_o,
  output logic [RADIX-1:0] wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             carry_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg;
  logic [AW-1:0]    count_reg;
  logic             carry_reg;
  logic             mode_reg;
  logic             last_word;
  logic             zero;
  logic [RADIX-1:0] b_mux;

`ifdef ECC_ADDSUB_ZEROIZE_EN
  assign zero = zeroize_i;
`else
  assign zero = 1'b0;
`endif

  assign last_word = (count_reg == AW'(WORDS - 1));

  // Subtract inverts B bit by bit; the +1 arrives through the seeded carry.
  genvar gi;
  generate
    for (gi = 0; gi < RADIX; gi++) begin : g_b_inv
      assign b_mux[gi] = b_i[gi] ^ mode_reg;
    end
  endgenerate

  // Memory and adder drives are decoded from the state. The adder result
  // is written back in the same cycle.
  always_comb begin
    rd_en_o   = 1'b0;
    rd_addr_o = '0;
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    case (state_reg)
      FETCH: begin
        rd_en_o = 1'b1;
      end
      CALC: begin
        add_a_o   = a_i;
        add_b_o   = b_mux;
        add_cin_o = carry_reg;
        wr_en_o   = 1'b1;
        wr_addr_o = count_reg;
        wr_data_o = add_s_i;
        // Prefetch the next word so that it arrives for the next CALC cycle.
        if (!last_word) begin
          rd_en_o   = 1'b1;
          rd_addr_o = count_reg + AW'(1);
        end
      end
      default: ;
    endcase
    // A zeroize request hides any datapath value in the current cycle.
    if (zero) begin
      add_a_o   = '0;
      add_b_o   = '0;
      add_cin_o = 1'b0;
      wr_data_o = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      carry_reg <= 1'b0;
      mode_reg  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      carry_o   <= 1'b0;
    end else if (zero) begin
      state_reg <= IDLE;
      count_reg <= '0;
      carry_reg <= 1'b0;
      mode_reg  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      carry_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            mode_reg  <= sub_i;
            state_reg <= FETCH;
            busy_o    <= 1'b1;
            // The previous result stays visible until a new operation starts.
            carry_o   <= 1'b0;
          end
        end
        FETCH: begin
          // The seed carry is 1 for subtract, which completes the two's complement.
          carry_reg <= mode_reg;
          count_reg <= '0;
          state_reg <= CALC;
        end
        CALC: begin
          carry_reg <= add_cout_i;
          if (last_word) begin
            carry_o   <= add_cout_i;
            done_o    <= 1'b1;
            state_reg <= DONE;
          end else begin
            count_reg <= count_reg + AW'(1);
          end
        end
        DONE: begin
          count_reg <= '0;
          busy_o    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_addsub_seq_ctrl.sv
module tb_ecc_addsub_seq_ctrl;
  localparam int REG_SIZE = 64;
  localparam int RADIX    = 16;
  localparam int WORDS    = 4;
  localparam int AW       = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             zeroize;
  logic             start;
  logic             sub;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [RADIX-1:0] a_q, b_q;
  logic [RADIX-1:0] add_a, add_b, add_s;
  logic             add_cin, add_cout;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [RADIX-1:0] wr_data;
  logic             busy, done, carry;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [RADIX-1:0] mem_a [WORDS];
  logic [RADIX-1:0] mem_b [WORDS];

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] res;
    logic [3:0]  cin;    // bit k = expected add_cin_o while word k is processed
    logic        carry;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [1:0]  addr;
    logic [15:0] data;
    logic        cin;
  } wr_exp_t;

  typedef struct {
    int   cyc;
    logic carry;
  } done_exp_t;

  wr_exp_t   wq [$];
  done_exp_t dq [$];
  wr_exp_t   we;
  done_exp_t de;
  vec_t      vec [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand memory with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      a_q <= mem_a[rd_addr];
      b_q <= mem_b[rd_addr];
    end
  end

  // Behavioural RADIX-bit adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  ecc_addsub_seq_ctrl #(.REG_SIZE(REG_SIZE), .RADIX(RADIX)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ECC_ADDSUB_ZEROIZE_EN
    .zeroize_i (zeroize),
`endif
    .start_i   (start),
    .sub_i     (sub),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .a_i       (a_q),
    .b_i       (b_q),
    .add_a_o   (add_a),
    .add_b_o   (add_b),
    .add_cin_o (add_cin),
    .add_s_i   (add_s),
    .add_cout_i(add_cout),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .busy_o    (busy),
    .done_o    (done),
    .carry_o   (carry)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  always @(negedge clk) begin
    if (!reset && !zeroize) begin
      if (wr_en) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h at cyc %0d want no write", wr_addr, wr_data, cyc);
        end else begin
          we = wq.pop_front();
          $display("write cyc=%0d addr=%0d data=%04h cin=%0b", cyc, wr_addr, wr_data, add_cin);
          check("wr_addr", wr_addr, we.addr);
          check("wr_data", wr_data, we.data);
          check("add_cin", add_cin, we.cin);
          check("wr_cycle", cyc, we.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done at cyc %0d want none", cyc);
        end else begin
          de = dq.pop_front();
          $display("done  cyc=%0d carry=%0b", cyc, carry);
          check("carry_o", carry, de.carry);
          check("done_cycle", cyc, de.cyc);
        end
      end
    end
  end

  // Called #1 after a clock edge; start is sampled on the following edge
  // (edge 0). On return, base is set so that cycle n of the operation has cyc == base + n.
  task automatic issue(input vec_t v, output int base);
    for (int k = 0; k < WORDS; k++) begin
      mem_a[k] = v.a[16*k +: 16];
      mem_b[k] = v.b[16*k +: 16];
    end
    start = 1'b1;
    sub   = v.sub;
    @(posedge clk); #1;
    start = 1'b0;
    sub   = 1'b0;
    base  = cyc - 1;
    check("busy_fetch", busy, 1'b1);
    for (int k = 0; k < WORDS; k++)
      wq.push_back('{base + 2 + k, 2'(k), v.res[16*k +: 16], v.cin[k]});
    dq.push_back('{base + 6, v.carry});
  endtask

  // Called right after issue(); busy must stay high for cycles 1..6.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_busy_cycles"}, n, 6);
  endtask

  task automatic goto_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_add_a"}, add_a, '0);
    check({tag, "_wr_data"}, wr_data, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    vec[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 4'b1110, 1'b1};
    vec[1] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001, 1'b0};
    vec[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0, 4'b1111, 1'b1};
    vec[3] = '{64'h0001_0002_0003_8000, 64'h0000_0000_0000_8000, 1'b0, 64'h0001_0002_0004_0000, 4'b0010, 1'b0};
    vec[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 4'b0000, 1'b1};

    reset   = 1'b1;
    zeroize = 1'b0;
    start   = 1'b0;
    sub     = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    check("reset_carry", carry, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed operations, each run to completion.
    for (int i = 0; i < 5; i++) begin
      issue(vec[i], base);
      wait_idle($sformatf("vec%0d", i));
    end

    // A start pulse while busy (cycles 3 and 6) is ignored; a start in cycle 7 is accepted.
    @(posedge clk); #1;
    issue(vec[1], base);
    goto_cycle(base + 3);
    start = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    goto_cycle(base + 6);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_in_cycle7", busy, 1'b0);
    issue(vec[3], base);
    wait_idle("after_busy_start");

    // Reset during CALC k=1 aborts at once.
    @(posedge clk); #1;
    issue(vec[2], base);
    goto_cycle(base + 3);
    reset = 1'b1;
    #1;
    check_quiet("midreset");
    check("midreset_carry", carry, 1'b0);
    wq.delete();
    dq.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    issue(vec[4], base);
    wait_idle("after_reset");

`ifdef ECC_ADDSUB_ZEROIZE_EN
    // zeroize in cycle 4 together with start: datapath zeroed, then IDLE.
    @(posedge clk); #1;
    issue(vec[0], base);
    goto_cycle(base + 4);
    zeroize = 1'b1;
    start   = 1'b1;
    #1;
    check("zeroize_wr_data", wr_data, '0);
    check("zeroize_add_b", add_b, '0);
    check("zeroize_add_cin", add_cin, 1'b0);
    @(posedge clk); #1;
    zeroize = 1'b0;
    start   = 1'b0;
    wq.delete();
    dq.delete();
    check_quiet("zeroized");
    repeat (8) begin @(posedge clk); #1; end
    issue(vec[3], base);
    wait_idle("after_zeroize");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("pending_writes", wq.size(), 0);
    check("pending_dones", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
